imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the fetch stage reads. Receives a program image as a little-endian byte stream over a valid/ready channel, writes it into instruction memory one 32-bit word per write pulse, and holds the core in reset until the image is resident. On completion it releases the core and presents the image start address as the core's `pc_init`.

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a little-endian byte stream with an 8-byte header (start address, word
// count). It writes the image one 32-bit word per strobe and holds the core in
// reset until the last write has retired.
module imem_loader #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic [31:0] pc_init,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_DRAIN, S_DONE, S_ERROR} state_t;

  // Top of the legal byte range, kept 35 bits wide so the header check never wraps.
  localparam logic [34:0] MEM_BYTES = 35'(MEM_WORDS) << 2;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  hdr_cnt;
  logic [55:0] hdr;
  logic [1:0]  byte_cnt;
  logic [23:0] word;
  logic [31:0] wr_ptr;
  logic [31:0] remaining;

  logic        fire;
  logic [63:0] hdr_full;
  logic [31:0] hdr_start;
  logic [31:0] hdr_count;
  logic [34:0] hdr_end;
  logic        hdr_bad;
  logic        hdr_last;
  logic        word_last;

  // Decode the header as it completes and flag the final byte of each word.
  always_comb begin
    fire      = in_valid && in_ready;
    hdr_full  = {in_data, hdr};
    hdr_start = hdr_full[31:0];
    hdr_count = hdr_full[63:32];
    hdr_end   = {3'b000, hdr_start} + {1'b0, hdr_count, 2'b00};
    hdr_bad   = (hdr_start[1:0] != 2'b00) || (hdr_end > MEM_BYTES);
    hdr_last  = fire && (state == S_HDR) && (hdr_cnt == 3'd7);
    word_last = fire && (state == S_DATA) && (byte_cnt == 2'd3);
  end

  // Next-state logic; load_start overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (hdr_last) begin
          if (hdr_bad)                 state_nxt = S_ERROR;
          else if (hdr_count == 32'd0) state_nxt = S_DRAIN;
          else                         state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (word_last && (remaining == 32'd1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
    if (load_start) state_nxt = S_HDR;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR;
    else       state <= state_nxt;
  end

  // Registered outputs plus the header/word assembly datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b1;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      pc_init    <= 32'd0;
      hdr_cnt    <= 3'd0;
      byte_cnt   <= 2'd0;
      hdr        <= 56'd0;
      word       <= 24'd0;
      wr_ptr     <= 32'd0;
      remaining  <= 32'd0;
    end else begin
      in_ready   <= (state_nxt == S_HDR) || (state_nxt == S_DATA);
      core_reset <= (state_nxt != S_DONE);
      load_done  <= (state_nxt == S_DONE);
      load_error <= (state_nxt == S_ERROR);
      imem_we    <= 1'b0;
      if (load_start) begin
        // A byte arriving alongside load_start is consumed and dropped.
        hdr_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
      end else if (fire && (state == S_HDR)) begin
        hdr     <= hdr_full[63:8];
        hdr_cnt <= hdr_cnt + 3'd1;
        if (hdr_last && !hdr_bad) begin
          wr_ptr    <= hdr_start;
          remaining <= hdr_count;
          pc_init   <= hdr_start;
        end
      end else if (fire && (state == S_DATA)) begin
        word     <= {in_data, word[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
        if (word_last) begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_ptr;
          imem_wdata <= {in_data, word};
          wr_ptr     <= wr_ptr + 32'd4;
          remaining  <= remaining - 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed scenarios plus randomized images, checked
// every cycle against a byte-count based behavioural model.
module tb_imem_loader;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic [31:0] pc_init;
  logic        load_done;
  logic        load_error;

  int tests = 0;
  int fails = 0;

  imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .pc_init    (pc_init),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = taking bytes, 1 = draining, 2 = done, 3 = error
  logic [7:0]  got[$];
  int          phase;
  logic [31:0] m_start;
  logic [31:0] m_cnt;
  bit          model_live = 0;
  logic        exp_in_ready, exp_we, exp_core_reset, exp_done, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_pc;

  function automatic logic [31:0] le32(input int i);
    return {got[i+3], got[i+2], got[i+1], got[i]};
  endfunction

  initial begin
    int n;
    int k;
    forever begin
      @(posedge clk);
      exp_we = 1'b0;
      if (reset) begin
        got.delete();
        phase = 0;
        exp_pc = 32'd0;
        exp_addr = 32'd0;
        exp_wdata = 32'd0;
        model_live = 1;
      end else if (load_start) begin
        got.delete();
        phase = 0;
      end else begin
        case (phase)
          0: if (in_valid) begin
            got.push_back(in_data);
            n = got.size();
            if (n == 8) begin
              m_start = le32(0);
              m_cnt   = le32(4);
              if (m_start[1:0] != 2'b00 ||
                  longint'(m_start) + longint'(m_cnt) * 4 > longint'(MEM_WORDS) * 4)
                phase = 3;
              else begin
                exp_pc = m_start;
                if (m_cnt == 0) phase = 1;
              end
            end else if (n > 8 && (n - 8) % 4 == 0) begin
              k = (n - 8) / 4;
              exp_we    = 1'b1;
              exp_addr  = m_start + 32'(4 * (k - 1));
              exp_wdata = le32(n - 4);
              if (k == int'(m_cnt)) phase = 1;
            end
          end
          1: phase = 2;
          default: ;
        endcase
      end
      exp_in_ready   = (phase == 0);
      exp_core_reset = (phase != 2);
      exp_done       = (phase == 2);
      exp_err        = (phase == 3);
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("in_ready",   32'(in_ready),   32'(exp_in_ready));
        check("imem_we",    32'(imem_we),    32'(exp_we));
        check("core_reset", 32'(core_reset), 32'(exp_core_reset));
        check("load_done",  32'(load_done),  32'(exp_done));
        check("load_error", 32'(load_error), 32'(exp_err));
        check("pc_init",    pc_init,         exp_pc);
        if (exp_we) begin
          check("imem_addr",  imem_addr,  exp_addr);
          check("imem_wdata", imem_wdata, exp_wdata);
        end
      end
    end
  end

  // Log of observed writes for the literal checks.
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wlog_a.push_back(imem_addr);
        wlog_d.push_back(imem_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  int gap_min = 0;
  int gap_max = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    int g;
    if (gap_max > 0) begin
      g = $urandom_range(gap_min, gap_max);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      cyc(g);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 200) begin
      cyc(1);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_byte: in_ready stayed 0 for 200 cycles, expected 1");
    end
    cyc(1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send32(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_start(input logic with_byte, input logic [7:0] b);
    load_start = 1'b1;
    in_valid   = with_byte;
    in_data    = b;
    cyc(1);
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int kind;
    int cnt;
    logic [31:0] st_a;
    reset = 1'b1;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    cyc(3);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset core_reset", 32'(core_reset), 32'd1);
    reset = 1'b0;
    cyc(1);

    // Two-word image at address 0.
    wb = wlog_a.size();
    send32(32'h0000_0000);
    send32(32'd2);
    send32(32'h0000_0013);
    send32(32'h0010_0093);
    check("t1 done one cycle after last byte", 32'(load_done), 32'd0);
    cyc(1);
    check("t1 done two cycles after last byte", 32'(load_done), 32'd1);
    check("t1 core released", 32'(core_reset), 32'd0);
    check("t1 pc_init", pc_init, 32'h0);
    check("t1 write count", 32'(wlog_a.size() - wb), 32'd2);
    if (wlog_a.size() >= wb + 2) begin
      check("t1 w0 addr", wlog_a[wb],   32'h0);
      check("t1 w0 data", wlog_d[wb],   32'h0000_0013);
      check("t1 w1 addr", wlog_a[wb+1], 32'h4);
      check("t1 w1 data", wlog_d[wb+1], 32'h0010_0093);
    end

    // Single word with in_valid alternating; starts from DONE.
    pulse_start(1'b0, 8'h00);
    check("t2 done drops", 32'(load_done), 32'd0);
    check("t2 core held", 32'(core_reset), 32'd1);
    wb = wlog_a.size();
    gap_min = 1; gap_max = 1;
    send32(32'h0000_0100);
    send32(32'd1);
    send32(32'h1234_5678);
    gap_min = 0; gap_max = 0;
    cyc(2);
    check("t2 write count", 32'(wlog_a.size() - wb), 32'd1);
    if (wlog_a.size() > wb) begin
      check("t2 addr", wlog_a[wb], 32'h100);
      check("t2 data", wlog_d[wb], 32'h1234_5678);
    end
    check("t2 pc_init", pc_init, 32'h100);
    check("t2 done", 32'(load_done), 32'd1);

    // Rejected headers: misaligned, past the end, and a count that wraps 32 bits.
    wb = wlog_a.size();
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0102);
    send32(32'd1);
    check("t3 misaligned error", 32'(load_error), 32'd1);
    check("t3 in_ready low", 32'(in_ready), 32'd0);
    cyc(3);
    check("t3 core held", 32'(core_reset), 32'd1);
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0FFC);
    send32(32'd2);
    check("t3 range error", 32'(load_error), 32'd1);
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0000);
    send32(32'h4000_0000);
    check("t3 wrap error", 32'(load_error), 32'd1);
    cyc(2);
    check("t3 no writes", 32'(wlog_a.size() - wb), 32'd0);

    // Image ending exactly at the top of memory is legal.
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0FF8);
    send32(32'd2);
    send32(32'hDEAD_BEEF);
    send32(32'hCAFE_F00D);
    cyc(2);
    check("t3b top image done", 32'(load_done), 32'd1);
    check("t3b last addr", wlog_a[wlog_a.size()-1], 32'hFFC);

    // Empty image.
    wb = wlog_a.size();
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0040);
    send32(32'd0);
    check("t4 not yet done", 32'(load_done), 32'd0);
    cyc(1);
    check("t4 done", 32'(load_done), 32'd1);
    check("t4 pc_init", pc_init, 32'h40);
    check("t4 no writes", 32'(wlog_a.size() - wb), 32'd0);

    // Abort mid-word with a coincident byte, then a fresh header.
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0200);
    send32(32'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    wb = wlog_a.size();
    pulse_start(1'b1, 8'hAA);
    check("t5 core held", 32'(core_reset), 32'd1);
    send32(32'h0000_0300);
    send32(32'd1);
    send32(32'h4433_2211);
    cyc(2);
    check("t5 write count", 32'(wlog_a.size() - wb), 32'd1);
    if (wlog_a.size() > wb) begin
      check("t5 addr", wlog_a[wb], 32'h300);
      check("t5 data", wlog_d[wb], 32'h4433_2211);
    end
    check("t5 pc_init", pc_init, 32'h300);

    // Randomized images, bad headers, empty images and aborts.
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      gap_min = 0;
      gap_max = $urandom_range(0, 2);
      pulse_start(1'($urandom_range(0, 1)), 8'($urandom));
      cnt  = $urandom_range(1, 6);
      st_a = 32'($urandom_range(0, MEM_WORDS - cnt)) << 2;
      case (kind)
        0: begin send32(st_a | 32'($urandom_range(1, 3))); send32(32'(cnt)); end
        1: begin send32(32'((MEM_WORDS - cnt + $urandom_range(1, 3)) * 4)); send32(32'(cnt)); end
        2: begin send32(st_a); send32(32'd0); end
        3: begin
          send32(st_a);
          send32(32'(cnt));
          repeat ($urandom_range(0, 4 * cnt - 1)) send_byte(8'($urandom));
        end
        default: begin
          send32(st_a);
          send32(32'(cnt));
          repeat (4 * cnt) send_byte(8'($urandom));
        end
      endcase
      cyc(3);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        cyc(3);
        in_valid = 1'b0;
      end
    end

    // Reset in the middle of operation returns everything to reset values.
    pulse_start(1'b0, 8'h00);
    send32(32'h0000_0010);
    send32(32'd4);
    send_byte(8'h55);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("reset pc_init", pc_init, 32'h0);
    check("reset in_ready again", 32'(in_ready), 32'd1);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
